// File: rtl/ysyx_24080006_bus_err_resp.sv
// Default AXI4 slave: terminates unrouted or direction-illegal accesses with DECERR/SLVERR bursts.
// Read beats start 1 cycle after AR; B is 1 cycle after wlast; all outputs registered and held under backpressure.
module ysyx_24080006_bus_err_resp #(
  parameter int          NPC_MODE   = 0,
  parameter int          ID_W       = 4,
  parameter logic [31:0] RDATA_FILL = 32'hdead_beef,
  parameter int          CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      awaddr,
  input  logic [ID_W-1:0]  awid,
  input  logic [7:0]       awlen,

  input  logic             wvalid,
  output logic             wready,
  input  logic             wlast,

  output logic             bvalid,
  input  logic             bready,
  output logic [1:0]       bresp,
  output logic [ID_W-1:0]  bid,

  input  logic             arvalid,
  output logic             arready,
  input  logic [31:0]      araddr,
  input  logic [ID_W-1:0]  arid,
  input  logic [7:0]       arlen,

  output logic             rvalid,
  input  logic             rready,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic [ID_W-1:0]  rid,
  output logic             rlast,

  input  logic             err_clr,
  output logic             err_valid,
  output logic [31:0]      err_addr,
  output logic             err_is_write,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic in_range(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  // Anything that is readable somewhere is a real device, so a fault there is a
  // slave error; only addresses no device decodes get DECERR. The store-legal set
  // is a subset of this one, so it never changes the response code.
  function automatic logic load_legal(input logic [31:0] a);
    logic hit;
    hit = in_range(a, 32'h0f00_0000, 32'h0f00_1fff)
        | in_range(a, 32'h3000_0000, 32'h30ff_ffff)
        | in_range(a, 32'ha000_0000, 32'ha3ff_ffff)
        | in_range(a, 32'h0200_0000, 32'h0200_ffff)
        | in_range(a, 32'h1000_0000, 32'h1000_0fff)
        | in_range(a, 32'h1000_2000, 32'h1000_200f)
        | in_range(a, 32'h1001_1000, 32'h1001_1007)
        | in_range(a, 32'h2100_0000, 32'h211f_ffff);
    if (NPC_MODE != 0)
      hit = hit | in_range(a, 32'h8000_0000, 32'h87ff_ffff);
    return hit;
  endfunction

  function automatic logic [1:0] resp_code(input logic [31:0] a);
    return load_legal(a) ? RESP_SLVERR : RESP_DECERR;
  endfunction

  logic ar_hs;
  logic aw_hs;
  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;

  assign rdata = RDATA_FILL;

  // Burst termination is by wlast only, so awlen carries no information here.
  logic unused_awlen;
  assign unused_awlen = ^awlen;

  // ---------------------------------------------------------------- read
  r_state_t   r_state;
  logic [7:0] r_len;
  logic [7:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= 2'b00;
      rid     <= '0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_DATA;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rlast   <= (arlen == 8'd0);
            rresp   <= resp_code(araddr);
            rid     <= arid;
            r_len   <= arlen;
            r_cnt   <= 8'd0;
          end
        end
        R_DATA: begin
          if (rvalid && rready) begin
            if (rlast) begin
              r_state <= R_IDLE;
              arready <= 1'b1;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: begin
          r_state <= R_IDLE;
          arready <= 1'b1;
          rvalid  <= 1'b0;
          rlast   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- write
  w_state_t w_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      bid     <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_state <= W_DATA;
            awready <= 1'b0;
            wready  <= 1'b1;
            bresp   <= resp_code(awaddr);
            bid     <= awid;
          end
        end
        W_DATA: begin
          if (wvalid && wready && wlast) begin
            w_state <= W_RESP;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bvalid && bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
          end
        end
        default: begin
          w_state <= W_IDLE;
          awready <= 1'b1;
          wready  <= 1'b0;
          bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- fault capture
  logic [1:0]     cnt_inc;
  logic [CNT_W:0] cnt_sum;
  assign cnt_inc = {1'b0, ar_hs} + {1'b0, aw_hs};
  assign cnt_sum = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, cnt_inc};

  always_ff @(posedge clock) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_addr     <= 32'd0;
      err_is_write <= 1'b0;
      err_cnt      <= '0;
    end else begin
      // A new fault beats a simultaneous clear; a read beats a simultaneous write.
      if ((ar_hs || aw_hs) && (!err_valid || err_clr)) begin
        err_valid    <= 1'b1;
        err_addr     <= ar_hs ? araddr : awaddr;
        err_is_write <= !ar_hs;
      end else if (err_clr) begin
        err_valid    <= 1'b0;
        err_addr     <= 32'd0;
        err_is_write <= 1'b0;
      end
      if (cnt_sum[CNT_W])
        err_cnt <= '1;
      else
        err_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

endmodule
